// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall sequencer and its watchdog.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } seq_state_e;

  localparam int MD_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF      = 32;
  localparam int WD_W_DEF       = $clog2(MD_TIMEOUT_DEF + 1);

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipe_stall_sequencer_if.sv
// Hazard/handshake inputs and stall controls between hazard detection and the sequencer.
interface pipe_stall_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             haz_load_use;
  logic             haz_branch_ex;
  logic             haz_branch_mem;
  logic             branch_taken;
  logic             md_req;
  logic             md_done;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_hold;
  logic             ex_mem_bubble;
  logic             md_start;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output haz_load_use, haz_branch_ex, haz_branch_mem, branch_taken, md_req, md_done,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble,
           md_start, md_err, stall_cnt
  );

  modport slave (
    input  haz_load_use, haz_branch_ex, haz_branch_mem, branch_taken, md_req, md_done,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble,
           md_start, md_err, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_sequencer_md_watchdog.sv
// Mult/div wait watchdog: counts MD_WAIT cycles, flags the MD_TIMEOUT-th one.
module md_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = wd_width(MD_TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the number of MD_WAIT cycles already completed, so the current cycle is cnt+1.
  assign expired = enable && (cnt == W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Five-stage pipeline stall/flush sequencer with mult/div wait and stall counter.
// Build option: DELAY_SLOT_EN suppresses the taken-branch IF/ID flush.
module pipe_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  pipe_stall_sequencer_if.slave bus
);
  // state   | meaning
  // RUN     | normal issue; hazards stall via bubble, md_req enters MD_WAIT
  // MD_WAIT | pipeline frozen until md_done or watchdog expiry

`ifdef DELAY_SLOT_EN
  localparam bit FLUSH_ON_BRANCH = 1'b0;
`else
  localparam bit FLUSH_ON_BRANCH = 1'b1;
`endif

  seq_state_e       state;
  logic             md_start_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             wd_expired;
  logic             any_haz;
  logic             go_wait;
  logic             md_exit;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic ex_hold, ex_mem_bubble, md_err;

  assign any_haz = bus.haz_load_use | bus.haz_branch_ex | bus.haz_branch_mem;

  md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_md_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == RUN),
    .enable  (state == MD_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    md_err        = 1'b0;
    go_wait       = 1'b0;
    md_exit       = 1'b0;
    // Controls are combinational, so reset has to force the safe stall pattern directly.
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == MD_WAIT) begin
      if (bus.md_done) begin
        md_exit = 1'b1;
      end else if (wd_expired) begin
        md_exit = 1'b1;
        md_err  = 1'b1;
      end else begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_hold       = 1'b1;
        ex_mem_bubble = 1'b1;
      end
    end else begin
      if (bus.md_req) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_hold       = 1'b1;
        ex_mem_bubble = 1'b1;
        go_wait       = 1'b1;
      end else if (any_haz) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (bus.branch_taken) begin
        if_id_flush = FLUSH_ON_BRANCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      md_start_q <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      case (state)
        RUN: begin
          if (go_wait) begin
            state      <= MD_WAIT;
            md_start_q <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_exit) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!pc_write) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.ex_hold       = ex_hold;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.md_start      = md_start_q;
  assign bus.md_err        = md_err;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Bench for pipe_stall_sequencer: vector table plus hand sequences for mult/div and reset.
module tb_pipe_stall_sequencer;
  localparam int TB_TIMEOUT = 6;
  localparam int TB_CNT_W   = 32;

  // inputs: {haz_load_use, haz_branch_ex, haz_branch_mem, branch_taken, md_req, md_done}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_LU   = 6'b100000;
  localparam logic [5:0] I_BEX  = 6'b010000;
  localparam logic [5:0] I_BMEM = 6'b001000;
  localparam logic [5:0] I_BR   = 6'b000100;
  localparam logic [5:0] I_REQ  = 6'b000010;
  localparam logic [5:0] I_DONE = 6'b000001;

  // outputs: {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble, md_start, md_err}
  localparam logic [7:0] O_RESET = 8'b0010_0000;
  localparam logic [7:0] O_RUN   = 8'b1100_0000;
  localparam logic [7:0] O_STALL = 8'b0010_0000;
  localparam logic [7:0] O_HOLD  = 8'b0000_1100;
  localparam logic [7:0] O_HSTRT = 8'b0000_1110;
  localparam logic [7:0] O_ERR   = 8'b1100_0001;
`ifdef DELAY_SLOT_EN
  localparam logic [7:0] O_FLUSH = 8'b1100_0000;
`else
  localparam logic [7:0] O_FLUSH = 8'b1101_0000;
`endif

  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [TB_CNT_W-1:0] exp_cnt;
  logic [7:0] sb[$];
  logic [7:0] outs;
  vec_t tbl[14];

  pipe_stall_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_stall_sequencer #(.MD_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign outs = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush,
                 bus.ex_hold, bus.ex_mem_bubble, bus.md_start, bus.md_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {bus.haz_load_use, bus.haz_branch_ex, bus.haz_branch_mem,
     bus.branch_taken, bus.md_req, bus.md_done} = in;
  endtask

  // One pipeline cycle: drive after the edge, push expectation, compare mid-cycle.
  task automatic step(input logic [5:0] in, input logic [7:0] exp, input string name);
    logic [7:0] e;
    @(posedge clk);
    #1;
    drive(in);
    sb.push_back(exp);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({name, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(name, {24'd0, outs}, {24'd0, e});
      chk({name, "_cnt"}, bus.stall_cnt, exp_cnt);
      if (!e[7]) exp_cnt++;
    end
  endtask

  // md_req entry followed by n MD_WAIT cycles; last cycle optionally carries md_done.
  task automatic md_seq(input int n, input bit done_last, input string name);
    step(I_REQ, O_HOLD, {name, "_entry"});
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        if (done_last) step(I_REQ | I_DONE, O_RUN, {name, "_exit"});
        else if (k == TB_TIMEOUT) step(I_REQ, O_ERR, {name, "_wd"});
        else step(I_REQ, O_HOLD, {name, "_wait"});
      end else if (k == 1) begin
        step(I_REQ, O_HSTRT, {name, "_start"});
      end else begin
        step(I_REQ, O_HOLD, {name, "_wait"});
      end
    end
    step(I_NONE, O_RUN, {name, "_after"});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = '0;
    rst_n    = 1'b0;
    drive(I_NONE);

    tbl[0]  = '{I_NONE,                         O_RUN,   "idle"};
    tbl[1]  = '{I_LU,                           O_STALL, "load_use"};
    tbl[2]  = '{I_NONE,                         O_RUN,   "after_lu"};
    tbl[3]  = '{I_BEX | I_BR,                   O_STALL, "br_dep_ex"};
    tbl[4]  = '{I_BMEM | I_BR,                  O_STALL, "br_dep_mem"};
    tbl[5]  = '{I_BR,                           O_FLUSH, "br_taken"};
    tbl[6]  = '{I_NONE,                         O_RUN,   "after_br"};
    tbl[7]  = '{I_DONE,                         O_RUN,   "done_in_run"};
    tbl[8]  = '{I_LU | I_BEX | I_BMEM | I_BR,   O_STALL, "all_haz"};
    tbl[9]  = '{I_REQ | I_LU | I_BR,            O_HOLD,  "req_over_haz"};
    tbl[10] = '{I_REQ | I_LU | I_BEX | I_BR,    O_HSTRT, "md_ignore_haz"};
    tbl[11] = '{I_REQ | I_BMEM,                 O_HOLD,  "md_hold"};
    tbl[12] = '{I_REQ | I_DONE | I_LU,          O_RUN,   "md_exit"};
    tbl[13] = '{I_NONE,                         O_RUN,   "no_retrigger"};

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_outs", {24'd0, outs}, {24'd0, O_RESET});
      chk("rst_cnt", bus.stall_cnt, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) step(tbl[i].in, tbl[i].exp, tbl[i].name);

    // md_req at cycle 10, md_done at cycle 15: five stall cycles.
    md_seq(5, 1'b1, "md_10_15");
    md_seq(TB_TIMEOUT, 1'b0, "md_timeout");
    md_seq(TB_TIMEOUT, 1'b1, "md_done_vs_wd");
    md_seq(TB_TIMEOUT - 1, 1'b1, "md_done_early");

    // Reset dropped in the middle of MD_WAIT.
    step(I_REQ, O_HOLD, "mdrst_entry");
    step(I_REQ, O_HSTRT, "mdrst_start");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mdrst_outs", {24'd0, outs}, {24'd0, O_RESET});
    chk("mdrst_cnt", bus.stall_cnt, 32'd0);
    exp_cnt = '0;
    drive(I_NONE);
    @(negedge clk);
    @(negedge clk);
    chk("mdrst_hold", {24'd0, outs}, {24'd0, O_RESET});
    rst_n = 1'b1;
    step(I_NONE, O_RUN, "mdrst_rel1");
    step(I_NONE, O_RUN, "mdrst_rel2");
    step(I_LU, O_STALL, "mdrst_lu");
    step(I_NONE, O_RUN, "mdrst_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
